// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters and mispredict/perf counters. BP_GSHARE_EN adds a global history XORed into the index.
// Lookup is combinational with zero latency. Training is applied at posedge. There is no backpressure: one update per cycle.
module branch_target_predictor #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      fetch_pc,
   output logic             predict_taken,
   output logic [31:0]      predict_tgt,
   output logic [IDX_W-1:0] predict_hist,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic             upd_is_jump,
   input  logic [31:0]      upd_tgt,
   input  logic             upd_pred,
   input  logic [31:0]      upd_pred_tgt,
   input  logic [IDX_W-1:0] upd_hist,
   output logic             mispredict,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   logic             r_valid [DEPTH];
   logic [TAG_W-1:0] r_tag   [DEPTH];
   logic [31:0]      r_tgt   [DEPTH];
   logic [1:0]       r_ctr   [DEPTH];
   logic [CNT_W-1:0] r_br_count;
   logic [CNT_W-1:0] r_miss_count;

   logic [IDX_W-1:0] w_hist;
   logic [IDX_W-1:0] w_fidx;
   logic [IDX_W-1:0] w_uidx;
   logic             w_fhit;
   logic             w_uhit;
   logic             w_mis;
   logic [1:0]       w_ctr_nxt;
   logic [31:0]      w_fpc4;
   logic             w_unused;

`ifdef BP_GSHARE_EN
   logic [IDX_W-1:0] r_ghr;

   // History advances only on resolved conditional branches, so it never needs repair.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_ghr <= '0;
      else if (upd_valid && !upd_is_jump)
         r_ghr <= {r_ghr[IDX_W-2:0], upd_taken};
   end

   assign w_hist   = r_ghr;
   assign w_uidx   = upd_pc[IDX_W+1:2] ^ upd_hist;
   assign w_unused = ^{upd_pc[1:0], fetch_pc[1:0]};
`else
   assign w_hist   = '0;
   assign w_uidx   = upd_pc[IDX_W+1:2];
   assign w_unused = ^{upd_hist, upd_pc[1:0], fetch_pc[1:0]};
`endif

   assign w_fidx        = fetch_pc[IDX_W+1:2] ^ w_hist;
   assign w_fhit        = r_valid[w_fidx] && (r_tag[w_fidx] == fetch_pc[31:IDX_W+2]);
   assign w_fpc4        = fetch_pc + 32'd4;
   assign predict_taken = reset && w_fhit && r_ctr[w_fidx][1];
   assign predict_tgt   = predict_taken ? r_tgt[w_fidx] : w_fpc4;
   assign predict_hist  = w_hist;

   assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == upd_pc[31:IDX_W+2]);
   assign w_mis  = upd_valid && ((upd_taken != upd_pred) ||
                                 (upd_taken && upd_pred && (upd_tgt != upd_pred_tgt)));
   assign mispredict = reset && w_mis;

   always_comb begin
      w_ctr_nxt = r_ctr[w_uidx];
      if (upd_is_jump)
         w_ctr_nxt = 2'b11;
      else if (upd_taken) begin
         if (w_ctr_nxt != 2'b11)
            w_ctr_nxt = w_ctr_nxt + 2'd1;
      end else if (w_ctr_nxt != 2'b00)
         w_ctr_nxt = w_ctr_nxt - 2'd1;
   end

   // Not-taken misses never allocate, so cold branches keep falling through.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_tag[i]   <= '0;
            r_tgt[i]   <= '0;
            r_ctr[i]   <= 2'b01;
         end
      end else if (upd_valid) begin
         if (w_uhit) begin
            r_ctr[w_uidx] <= w_ctr_nxt;
            if (upd_taken)
               r_tgt[w_uidx] <= upd_tgt;
         end else if (upd_taken) begin
            r_valid[w_uidx] <= 1'b1;
            r_tag[w_uidx]   <= upd_pc[31:IDX_W+2];
            r_tgt[w_uidx]   <= upd_tgt;
            r_ctr[w_uidx]   <= upd_is_jump ? 2'b11 : 2'b10;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_br_count   <= '0;
         r_miss_count <= '0;
      end else begin
         if (upd_valid && !(&r_br_count))
            r_br_count <= r_br_count + 1'b1;
         if (w_mis && !(&r_miss_count))
            r_miss_count <= r_miss_count + 1'b1;
      end
   end

   assign br_count   = r_br_count;
   assign miss_count = r_miss_count;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed steps plus random traffic checked against a behavioural model.
module tb_branch_target_predictor;
   localparam int IDX_W = 6;
   localparam int CNT_W = 8;
   localparam int CMAX  = 255;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      fetch_pc;
   logic             predict_taken;
   logic [31:0]      predict_tgt;
   logic [IDX_W-1:0] predict_hist;
   logic             upd_valid;
   logic [31:0]      upd_pc;
   logic             upd_taken;
   logic             upd_is_jump;
   logic [31:0]      upd_tgt;
   logic             upd_pred;
   logic [31:0]      upd_pred_tgt;
   logic [IDX_W-1:0] upd_hist;
   logic             mispredict;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] miss_count;

   int checks = 0;
   int errors = 0;

   // Behavioural model: each slot remembers the full PC that owns it and an integer confidence 0..3.
   bit          m_valid [64];
   logic [31:0] m_pc    [64];
   logic [31:0] m_tgt   [64];
   int          m_ctr   [64];
   int          m_ghr;
   int          m_br;
   int          m_miss;

   branch_target_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
      .predict_taken(predict_taken), .predict_tgt(predict_tgt), .predict_hist(predict_hist),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_is_jump(upd_is_jump),
      .upd_tgt(upd_tgt), .upd_pred(upd_pred), .upd_pred_tgt(upd_pred_tgt), .upd_hist(upd_hist),
      .mispredict(mispredict), .br_count(br_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int slot(input logic [31:0] pc, input int hist);
      return int'(((pc >> 2) ^ 32'(hist)) & 32'd63);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 0;
         m_pc[i]    = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
      m_ghr  = 0;
      m_br   = 0;
      m_miss = 0;
   endtask

   task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
      int  i;
      bit  hit;
      i   = slot(pc, m_ghr);
      hit = m_valid[i] && ((m_pc[i] >> 8) == (pc >> 8));
      tk  = hit && (m_ctr[i] >= 2);
      tgt = tk ? m_tgt[i] : pc + 32'd4;
   endtask

   function automatic logic m_mis(input logic tk, input logic [31:0] tgt,
                                  input logic pr, input logic [31:0] prt);
      return (tk != pr) || (tk && pr && (tgt != prt));
   endfunction

   task automatic m_update(input logic [31:0] pc, input logic tk, input logic jmp,
                           input logic [31:0] tgt, input logic pr, input logic [31:0] prt,
                           input int hist);
      int i;
      bit hit;
`ifdef BP_GSHARE_EN
      i = slot(pc, hist);
`else
      i = slot(pc, 0);
`endif
      hit = m_valid[i] && ((m_pc[i] >> 8) == (pc >> 8));
      if (hit) begin
         if (jmp)     m_ctr[i] = 3;
         else if (tk) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
         else         m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         if (tk) m_tgt[i] = tgt;
      end else if (tk) begin
         m_valid[i] = 1;
         m_pc[i]    = pc;
         m_tgt[i]   = tgt;
         m_ctr[i]   = jmp ? 3 : 2;
      end
`ifdef BP_GSHARE_EN
      if (!jmp) m_ghr = ((m_ghr << 1) | int'(tk)) & 63;
`endif
      if (m_br < CMAX) m_br++;
      if (m_mis(tk, tgt, pr, prt) && m_miss < CMAX) m_miss++;
   endtask

   // One cycle: drive at negedge, check combinational outputs before the edge, then train the model.
   task automatic step(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                       input logic utk, input logic ujmp, input logic [31:0] utgt,
                       input logic upr, input logic [31:0] uprt);
      logic        et;
      logic [31:0] etgt;
      @(negedge clk);
      fetch_pc     = fpc;
      upd_valid    = uv;
      upd_pc       = upc;
      upd_taken    = utk;
      upd_is_jump  = ujmp;
      upd_tgt      = utgt;
      upd_pred     = upr;
      upd_pred_tgt = uprt;
`ifdef BP_GSHARE_EN
      upd_hist = IDX_W'(m_ghr);
`else
      upd_hist = IDX_W'($urandom);
`endif
      #1;
      m_lookup(fpc, et, etgt);
      check("predict_taken", 32'(predict_taken), 32'(et));
      check("predict_tgt", predict_tgt, etgt);
`ifdef BP_GSHARE_EN
      check("predict_hist", 32'(predict_hist), 32'(m_ghr));
`else
      check("predict_hist", 32'(predict_hist), 32'd0);
`endif
      check("mispredict", 32'(mispredict), 32'(uv && m_mis(utk, utgt, upr, uprt)));
      check("br_count", 32'(br_count), 32'(m_br));
      check("miss_count", 32'(miss_count), 32'(m_miss));
      @(posedge clk);
      if (uv) m_update(upc, utk, ujmp, utgt, upr, uprt, int'(upd_hist));
   endtask

   initial begin
      logic [31:0] upc, fpc, utgt, pt, prt;
      logic        p, ujmp, utk, upr, uv;

      m_reset();
      reset = 1'b0;
      fetch_pc = 32'h100;
      upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_is_jump = 1'b0;
      upd_tgt = 32'h80; upd_pred = 1'b0; upd_pred_tgt = '0; upd_hist = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_predict_taken", 32'(predict_taken), 32'd0);
      check("rst_predict_tgt", predict_tgt, 32'h104);
      check("rst_mispredict", 32'(mispredict), 32'd0);
      check("rst_br_count", 32'(br_count), 32'd0);
      check("rst_miss_count", 32'(miss_count), 32'd0);
      check("rst_predict_hist", 32'(predict_hist), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      upd_valid = 1'b0;

      // First taken update with a same-cycle lookup that must still see the old entry.
      step(32'h100, 1, 32'h100, 1, 0, 32'h80, 0, 32'h0);
      step(32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      check("trained_tgt", predict_tgt, 32'h80);

      // Counter walk: 10 -> 01 -> 00, then up to 11 and saturate.
      step(32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 32'h80);
      step(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 32'h0);
      step(32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      check("cold_after_2nt", 32'(predict_taken), 32'd0);
      for (int k = 0; k < 4; k++) step(32'h100, 1, 32'h100, 1, 0, 32'h80, 0, 32'h0);
      step(32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 32'h80);
      step(32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      check("sat_then_nt_taken", 32'(predict_taken), 32'd1);

      // Aliasing: 0x200 shares the slot of 0x100.
      step(32'h100, 1, 32'h200, 1, 0, 32'h300, 0, 32'h0);
      step(32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      check("alias_evicted", predict_tgt, 32'h104);
      step(32'h200, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      check("alias_new_tgt", predict_tgt, 32'h300);

      // Jump with only a target mismatch.
      step(32'h200, 1, 32'h200, 1, 1, 32'h440, 1, 32'h300);

      // Reset mid-run: predictions fall back immediately and a coincident update is dropped.
      @(negedge clk);
      fetch_pc = 32'h200; upd_valid = 1'b1; upd_pc = 32'h204; upd_taken = 1'b1;
      upd_is_jump = 1'b0; upd_tgt = 32'h500; upd_pred = 1'b0;
      reset = 1'b0;
      #1;
      check("midrst_taken", 32'(predict_taken), 32'd0);
      check("midrst_tgt", predict_tgt, 32'h204);
      check("midrst_mispredict", 32'(mispredict), 32'd0);
      check("midrst_br_count", 32'(br_count), 32'd0);
      m_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      upd_valid = 1'b0;
      step(32'h204, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      step(32'h200, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

      // Random traffic over a few aliasing slots.
      for (int k = 0; k < 300; k++) begin
         upc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
         fpc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
         ujmp = ($urandom_range(0, 7) == 0);
         utk  = ujmp | 1'($urandom_range(0, 1));
         utgt = $urandom & 32'hFFFF_FFFC;
         uv   = ($urandom_range(0, 4) != 0);
         m_lookup(upc, p, pt);
         upr  = ($urandom_range(0, 3) == 0) ? ~p : p;
         prt  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pt;
         step(fpc, uv, upc, utk, ujmp, utgt, upr, prt);
      end

      // Drive both counters into saturation.
      for (int k = 0; k < 260; k++) step(32'h100, 1, 32'h1000, 0, 0, 32'h0, 1, 32'h0);
      step(32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      check("br_count_sat", 32'(br_count), 32'd255);
      check("miss_count_sat", 32'(miss_count), 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
